lane_serializer: RTL and testbench

Per-lane parallel-to-serial stage that sits directly downstream of the byte-striping demux; one instance is placed on each lane output (out0..out3 with valid_outN). It accepts 8-bit symbols through a valid/ready handshake and shifts them out MSB-first, one bit per clk. It inserts lane-sync COM symbols after reset and COM/IDL filler whenever no data is offered.

---
 rtl/lane_serializer.sv | 75 +++++++
 tb/tb_lane_serializer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/lane_serializer.sv
// Per-lane parallel-to-serial stage: accepts 8-bit symbols on valid/ready and shifts them out MSB-first,
// covering reset-time lane sync with COM symbols and data gaps with alternating COM/IDL filler.
module lane_serializer #(
    parameter int                DATA_W         = 8,
    parameter logic [DATA_W-1:0] COM_SYM        = 8'hBC,
    parameter logic [DATA_W-1:0] IDL_SYM        = 8'h7C,
    parameter int                SYNC_COM_COUNT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_bit,
    output logic              out_sym_start,
    output logic              out_active
);

    localparam int                SYNC_W    = $clog2(SYNC_COM_COUNT + 1);
    localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_COM_COUNT - 1);
    localparam logic [0:0]        ST_SYNC   = 1'b0;
    localparam logic [0:0]        ST_RUN    = 1'b1;
    localparam logic [2:0]        BIT_LAST  = 3'd7;

    logic [DATA_W-1:0] shift_reg;
    logic [2:0]        bit_cnt;
    logic [0:0]        state;
    logic [SYNC_W-1:0] sync_cnt;
    logic              idle_phase;
    logic              sym_is_data;

    function automatic logic [DATA_W-1:0] filler_sym(input logic phase);
        return phase ? IDL_SYM : COM_SYM;
    endfunction

    // Boundary cycle (bit_cnt==7) loads the next symbol; every other cycle shifts one bit out
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_reg   <= '0;
            bit_cnt     <= BIT_LAST;
            state       <= ST_SYNC;
            sync_cnt    <= '0;
            idle_phase  <= 1'b0;
            sym_is_data <= 1'b0;
        end else if (bit_cnt == BIT_LAST) begin
            bit_cnt <= 3'd0;
            if (state == ST_SYNC) begin
                shift_reg   <= COM_SYM;
                sym_is_data <= 1'b0;
                sync_cnt    <= sync_cnt + 1'b1;
                if (sync_cnt == SYNC_LAST) begin
                    state      <= ST_RUN;
                    idle_phase <= 1'b1;
                end
            end else if (in_valid) begin
                shift_reg   <= in_data;
                sym_is_data <= 1'b1;
                idle_phase  <= 1'b0;
            end else begin
                shift_reg   <= filler_sym(idle_phase);
                sym_is_data <= 1'b0;
                idle_phase  <= ~idle_phase;
            end
        end else begin
            shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
            bit_cnt   <= bit_cnt + 3'd1;
        end
    end

    assign out_bit       = shift_reg[DATA_W-1];
    assign out_sym_start = (bit_cnt == 3'd0) && !reset;
    assign out_active    = sym_is_data;
    assign in_ready      = (state == ST_RUN) && (bit_cnt == BIT_LAST);

endmodule

// File: tb/tb_lane_serializer.sv
// Directed bench for lane_serializer: captures whole serial symbols and compares them with hand-computed values.
module tb_lane_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       out_bit;
    logic       out_sym_start;
    logic       out_active;

    int n_total = 0;
    int n_pass  = 0;

    localparam logic [7:0] COM = 8'hBC;
    localparam logic [7:0] IDL = 8'h7C;

    lane_serializer dut (
        .clk           (clk),
        .reset         (reset),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_bit       (out_bit),
        .out_sym_start (out_sym_start),
        .out_active    (out_active)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called on the first cycle of a symbol; drives in_valid per bit from vdrive (MSB = first cycle)
    task automatic grab(input string tag, input logic [7:0] vdrive, input logic [7:0] exp_sym,
                        input logic [7:0] exp_act, input logic [7:0] exp_rdy);
        logic [7:0] sym, act, st, rdy;
        sym = '0; act = '0; st = '0; rdy = '0;
        for (int i = 0; i < 8; i++) begin
            in_valid = vdrive[7-i];
            sym = {sym[6:0], out_bit};
            act = {act[6:0], out_active};
            st  = {st[6:0], out_sym_start};
            rdy = {rdy[6:0], in_ready};
            tick();
        end
        check({tag, ".sym"},   32'(sym), 32'(exp_sym));
        check({tag, ".act"},   32'(act), 32'(exp_act));
        check({tag, ".start"}, 32'(st),  32'h80);
        check({tag, ".rdy"},   32'(rdy), 32'(exp_rdy));
    endtask

    task automatic reset_checks(input string tag);
        check({tag, ".bit"},   32'(out_bit), 32'd0);
        check({tag, ".start"}, 32'(out_sym_start), 32'd0);
        check({tag, ".act"},   32'(out_active), 32'd0);
        check({tag, ".rdy"},   32'(in_ready), 32'd0);
    endtask

    initial begin
        reset    = 1'b1;
        in_data  = 8'h00;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_checks("por");

        // Sync sequence then alternating filler
        reset = 1'b0;
        tick();
        grab("t1.com1", 8'h00, COM, 8'h00, 8'h00);
        grab("t1.com2", 8'h00, COM, 8'h00, 8'h00);
        grab("t1.com3", 8'h00, COM, 8'h00, 8'h00);
        grab("t1.com4", 8'h00, COM, 8'h00, 8'h01);
        grab("t1.idl1", 8'h00, IDL, 8'h00, 8'h01);
        grab("t1.com5", 8'h00, COM, 8'h00, 8'h01);
        grab("t1.idl2", 8'h00, IDL, 8'h00, 8'h01);

        // Back-to-back data
        in_data = 8'hA5;
        grab("t2.com", 8'hFF, COM, 8'h00, 8'h01);
        in_data = 8'h3C;
        grab("t2.a5", 8'hFF, 8'hA5, 8'hFF, 8'h01);
        grab("t2.3c", 8'h00, 8'h3C, 8'hFF, 8'h01);
        grab("t2.com_after", 8'h00, COM, 8'h00, 8'h01);
        grab("t2.idl_after", 8'h00, IDL, 8'h00, 8'h01);

        // Valid pulse that misses the boundary
        in_data = 8'h99;
        grab("t4.com", 8'h78, COM, 8'h00, 8'h01);
        grab("t4.idl", 8'h00, IDL, 8'h00, 8'h01);

        // Single data symbol then filler restarts at COM
        in_data = 8'hFF;
        grab("t5.com", 8'hFF, COM, 8'h00, 8'h01);
        grab("t5.ff", 8'h00, 8'hFF, 8'hFF, 8'h01);
        grab("t5.com_a", 8'h00, COM, 8'h00, 8'h01);
        grab("t5.idl", 8'h00, IDL, 8'h00, 8'h01);
        grab("t5.com_b", 8'h00, COM, 8'h00, 8'h01);

        // Reset in the middle of a data symbol
        in_data = 8'hC3;
        grab("t6.idl", 8'hFF, IDL, 8'h00, 8'h01);
        in_valid = 1'b0;
        tick();
        check("t6.pre.bit", 32'(out_bit), 32'd1);
        check("t6.pre.act", 32'(out_active), 32'd1);
        reset = 1'b1;
        #1;
        reset_checks("t6.async");
        repeat (2) tick();
        reset_checks("t6.hold");
        reset = 1'b0;
        tick();
        grab("t6.com1", 8'h00, COM, 8'h00, 8'h00);
        grab("t6.com2", 8'h00, COM, 8'h00, 8'h00);
        grab("t6.com3", 8'h00, COM, 8'h00, 8'h00);
        grab("t6.com4", 8'h00, COM, 8'h00, 8'h01);
        grab("t6.idl_after", 8'h00, IDL, 8'h00, 8'h01);

        // Data offered throughout sync is taken only at the first RUN boundary
        reset = 1'b1;
        repeat (2) tick();
        in_data  = 8'h55;
        in_valid = 1'b1;
        reset    = 1'b0;
        tick();
        grab("t3.com1", 8'hFF, COM, 8'h00, 8'h00);
        grab("t3.com2", 8'hFF, COM, 8'h00, 8'h00);
        grab("t3.com3", 8'hFF, COM, 8'h00, 8'h00);
        grab("t3.com4", 8'hFF, COM, 8'h00, 8'h01);
        grab("t3.55", 8'h00, 8'h55, 8'hFF, 8'h01);
        grab("t3.com_after", 8'h00, COM, 8'h00, 8'h01);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
